mmcm_phaseshift_multi: RTL and testbench

Multi-channel successor to the single-DCM phase-shift interface. Steps up to NUM_CH independent MMCM/DCM variable phase-shift ports toward signed per-channel targets, one step at a time under a shared round-robin sequencer. Adds lock-loss tracking, PSDONE timeout detection and target clamping. Sits in clock management on clk_usb, between the register interface and the clock primitives' PSEN/PSINCDEC/PSDONE pins.

---
 rtl/mmcm_phaseshift_multi.sv | 185 ++++++++++++++++++
 tb/tb_mmcm_phaseshift_multi.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_phaseshift_multi.sv
// Multi-channel MMCM/DCM variable phase-shift sequencer.
// Steps each channel's PSEN/PSINCDEC toward a clamped signed target, one step
// per round-robin grant, with lock-loss handling and PSDONE timeout detection.
module mmcm_phaseshift_multi #(
    parameter int NUM_CH      = 2,
    parameter int PHASE_W     = 10,
    parameter int MAX_PHASE   = 255,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                        clk_usb,
    input  logic                        reset,
    input  logic [NUM_CH*PHASE_W-1:0]   phase_requested,
    input  logic [NUM_CH-1:0]           phase_load,
    output logic [NUM_CH*PHASE_W-1:0]   phase_actual,
    output logic [NUM_CH-1:0]           phase_done,
    output logic [NUM_CH-1:0]           phase_timeout,
    output logic                        busy,
    output logic [NUM_CH-1:0]           ps_en,
    output logic [NUM_CH-1:0]           ps_incdec,
    input  logic [NUM_CH-1:0]           ps_done,
    input  logic [NUM_CH-1:0]           ps_locked
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic signed [PHASE_W-1:0] PH_MAX  = PHASE_W'(MAX_PHASE);
    localparam logic signed [PHASE_W-1:0] PH_MIN  = -PH_MAX;
    localparam logic signed [PHASE_W-1:0] PH_ONE  = PHASE_W'(1);
    localparam logic [CNT_W-1:0]          TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W-1:0]          LAST_CH = SEL_W'(NUM_CH - 1);

    logic [1:0]                   state;
    logic [SEL_W-1:0]             sel;
    logic [SEL_W-1:0]             rr_ptr;
    logic [SEL_W-1:0]             next_ptr;
    logic [SEL_W-1:0]             arb_idx;
    logic                         arb_hit;
    logic [CNT_W-1:0]             tcnt;
    logic signed [PHASE_W-1:0]    target [NUM_CH];
    logic signed [PHASE_W-1:0]    actual [NUM_CH];
    logic [NUM_CH-1:0]            pending;
    logic [NUM_CH-1:0]            done_c;

    function automatic logic signed [PHASE_W-1:0] clamp_phase(input logic signed [PHASE_W-1:0] v);
        if (v > PH_MAX)
            return PH_MAX;
        else if (v < PH_MIN)
            return PH_MIN;
        else
            return v;
    endfunction

    // Per-channel work-remaining and settled status
    always_comb begin
        pending = '0;
        done_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pending[i] = (target[i] != actual[i]) && ps_locked[i] && !phase_timeout[i];
            done_c[i]  = !pending[i] && (target[i] == actual[i]) && ps_locked[i] &&
                         !(((state == ST_STEP) || (state == ST_WAIT)) && (sel == SEL_W'(i)));
        end
    end

    // Round-robin search: first pending channel at or after rr_ptr, wrapping
    always_comb begin
        int unsigned c;
        arb_hit = 1'b0;
        arb_idx = '0;
        c       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            c = 32'(rr_ptr) + k;
            if (c >= NUM_CH)
                c = c - NUM_CH;
            if (!arb_hit && pending[SEL_W'(c)]) begin
                arb_hit = 1'b1;
                arb_idx = SEL_W'(c);
            end
        end
    end

    // Pointer advances past the channel just served so channels interleave
    always_comb begin
        next_ptr = (sel == LAST_CH) ? '0 : sel + 1'b1;
    end

    // Target capture with clamping on each channel's load pulse
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                target[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                if (phase_load[i])
                    target[i] <= clamp_phase(phase_requested[i*PHASE_W +: PHASE_W]);
        end
    end

    // Shared step sequencer: grant, pulse PSEN, await PSDONE or timeout
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sel           <= '0;
            rr_ptr        <= '0;
            tcnt          <= '0;
            ps_en         <= '0;
            ps_incdec     <= '0;
            phase_timeout <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++)
                actual[i] <= '0;
        end else begin
            ps_en <= '0;
            case (state)
                ST_IDLE: begin
                    if (|pending)
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (arb_hit) begin
                        sel                <= arb_idx;
                        ps_en[arb_idx]     <= 1'b1;
                        ps_incdec          <= '0;
                        ps_incdec[arb_idx] <= (target[arb_idx] > actual[arb_idx]);
                        state              <= ST_STEP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!ps_locked[sel]) begin
                        state  <= ST_ARB;
                        rr_ptr <= next_ptr;
                    end else if (ps_done[sel]) begin
                        actual[sel] <= ps_incdec[sel] ? (actual[sel] + PH_ONE)
                                                      : (actual[sel] - PH_ONE);
                        state       <= ST_ARB;
                        rr_ptr      <= next_ptr;
                    end else if (tcnt == TO_LAST) begin
                        phase_timeout[sel] <= 1'b1;
                        state              <= ST_ARB;
                        rr_ptr             <= next_ptr;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A primitive that loses lock restarts at zero phase; a fresh load
            // rearms a channel that had timed out.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!ps_locked[i])
                    actual[i] <= '0;
                if (phase_load[i])
                    phase_timeout[i] <= 1'b0;
            end
        end
    end

    // Registered settled flags; a load always clears its flag for one cycle
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset)
            phase_done <= '1;
        else
            phase_done <= done_c & ~phase_load;
    end

    // Pack per-channel phase onto the output bus
    always_comb begin
        phase_actual = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            phase_actual[i*PHASE_W +: PHASE_W] = actual[i];
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mmcm_phaseshift_multi.sv
// Self-checking bench for mmcm_phaseshift_multi: directed scenarios plus
// randomized loads checked against a round-robin reference model.
module tb_mmcm_phaseshift_multi;

    localparam int NCH  = 2;
    localparam int PW   = 10;
    localparam int MAXP = 255;
    localparam int TOC  = 1023;

    logic                 clk_usb = 1'b0;
    logic                 reset;
    logic [NCH*PW-1:0]    phase_requested;
    logic [NCH-1:0]       phase_load;
    logic [NCH*PW-1:0]    phase_actual;
    logic [NCH-1:0]       phase_done;
    logic [NCH-1:0]       phase_timeout;
    logic                 busy;
    logic [NCH-1:0]       ps_en;
    logic [NCH-1:0]       ps_incdec;
    logic [NCH-1:0]       ps_done;
    logic [NCH-1:0]       ps_locked;

    mmcm_phaseshift_multi #(
        .NUM_CH(NCH), .PHASE_W(PW), .MAX_PHASE(MAXP), .TIMEOUT_CYC(TOC)
    ) dut (
        .clk_usb(clk_usb), .reset(reset),
        .phase_requested(phase_requested), .phase_load(phase_load),
        .phase_actual(phase_actual), .phase_done(phase_done),
        .phase_timeout(phase_timeout), .busy(busy),
        .ps_en(ps_en), .ps_incdec(ps_incdec),
        .ps_done(ps_done), .ps_locked(ps_locked)
    );

    always #5 clk_usb = ~clk_usb;

    int n_cmp = 0;
    int n_err = 0;
    int lat[NCH];
    bit resp_en[NCH];
    int rcnt[NCH];
    int inc_cnt[NCH];
    int dec_cnt[NCH];
    int viol;
    int en_unlocked;
    int grant_q[$];
    int exp_q[$];
    int m_ptr;

    // Primitive model: PSDONE pulses lat[i] cycles after PSEN
    always @(negedge clk_usb) begin
        for (int i = 0; i < NCH; i++) begin
            ps_done[i] = 1'b0;
            if (rcnt[i] > 0) begin
                rcnt[i]--;
                if (rcnt[i] == 0) ps_done[i] = 1'b1;
            end
            if (ps_en[i] && resp_en[i]) rcnt[i] = lat[i];
        end
    end

    // Observe grants, direction and PSEN legality
    always @(negedge clk_usb) begin
        if ($countones(ps_en) > 1) viol++;
        if ((ps_en & ~ps_locked) != '0) en_unlocked++;
        for (int i = 0; i < NCH; i++)
            if (ps_en[i]) begin
                grant_q.push_back(i);
                if (ps_incdec[i]) inc_cnt[i]++; else dec_cnt[i]++;
            end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_usb);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int act(input int i);
        logic signed [PW-1:0] v;
        v = phase_actual[i*PW +: PW];
        return int'(v);
    endfunction

    function automatic int clampv(input int v);
        if (v > MAXP) return MAXP;
        if (v < -MAXP) return -MAXP;
        return v;
    endfunction

    function automatic int absv(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic clr_mon();
        for (int i = 0; i < NCH; i++) begin
            inc_cnt[i] = 0;
            dec_cnt[i] = 0;
        end
        viol        = 0;
        en_unlocked = 0;
        grant_q.delete();
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_actual"},  int'(phase_actual), 0);
        check({tag, "_rst_done"},    int'(phase_done), 3);
        check({tag, "_rst_timeout"}, int'(phase_timeout), 0);
        check({tag, "_rst_busy"},    int'(busy), 0);
        check({tag, "_rst_ps_en"},   int'(ps_en), 0);
        check({tag, "_rst_incdec"},  int'(ps_incdec), 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        m_ptr = 0;
    endtask

    task automatic load(input string tag, input logic [NCH-1:0] mask, input int v0, input int v1);
        logic [PW-1:0] s0, s1;
        s0 = PW'(v0);
        s1 = PW'(v1);
        phase_requested = {s1, s0};
        phase_load      = mask;
        tick(1);
        phase_load = '0;
        check({tag, "_done_drop"}, int'(phase_done & mask), 0);
        check({tag, "_to_clear"},  int'(phase_timeout & mask), 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int t = 0;
        while (quiet < 3 && t < budget) begin
            tick(1);
            t++;
            quiet = busy ? 0 : quiet + 1;
        end
        check({tag, "_settle"}, int'(quiet >= 3), 1);
    endtask

    // Reference grant order: serve first channel with remaining steps at or
    // after the pointer; the pointer then moves just past that channel.
    task automatic model_grants(input int r0, input int r1);
        int rem[NCH];
        rem[0] = r0;
        rem[1] = r1;
        exp_q.delete();
        while (rem[0] + rem[1] > 0) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (rem[c] > 0) begin
                    exp_q.push_back(c);
                    rem[c]--;
                    m_ptr = (c + 1) % NCH;
                    break;
                end
            end
        end
    endtask

    task automatic check_order(input string tag);
        int bad = 0;
        check({tag, "_order_len"}, grant_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < grant_q.size(); i++)
            if (grant_q[i] != exp_q[i]) bad++;
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        int t;
        int cur[NCH];
        int nt[NCH];
        int d[NCH];
        int v[NCH];
        logic [NCH-1:0] mask;

        reset           = 1'b0;
        phase_requested = '0;
        phase_load      = '0;
        ps_locked       = '1;
        ps_done         = '0;
        for (int i = 0; i < NCH; i++) begin
            lat[i]     = 10;
            resp_en[i] = 1'b1;
            rcnt[i]    = 0;
        end
        clr_mon();
        tick(1);

        // Single channel forward steps
        apply_reset("t1");
        clr_mon();
        load("t1", 2'b01, 5, 0);
        wait_idle("t1", 400);
        check("t1_act0", act(0), 5);
        check("t1_act1", act(1), 0);
        check("t1_done", int'(phase_done), 3);
        check("t1_busy", int'(busy), 0);
        check("t1_inc0", inc_cnt[0], 5);
        check("t1_dec0", dec_cnt[0], 0);
        check("t1_ch1_pulses", inc_cnt[1] + dec_cnt[1], 0);

        // Simultaneous loads interleave
        apply_reset("t2");
        clr_mon();
        load("t2", 2'b11, 3, -2);
        model_grants(3, 2);
        wait_idle("t2", 400);
        check_order("t2");
        check("t2_act0", act(0), 3);
        check("t2_act1", act(1), -2);
        check("t2_onehot", viol, 0);
        check("t2_inc0", inc_cnt[0], 3);
        check("t2_dec1", dec_cnt[1], 2);
        check("t2_done", int'(phase_done), 3);

        // Clamping at both limits
        apply_reset("t3");
        clr_mon();
        load("t3a", 2'b01, 400, 0);
        wait_idle("t3a", 6000);
        check("t3_act0_pos", act(0), MAXP);
        check("t3_inc0", inc_cnt[0], MAXP);
        check("t3_done_pos", int'(phase_done), 3);
        clr_mon();
        load("t3b", 2'b01, -300, 0);
        wait_idle("t3b", 11000);
        check("t3_act0_neg", act(0), -MAXP);
        check("t3_dec0", dec_cnt[0], 2 * MAXP);
        check("t3_done_neg", int'(phase_done), 3);

        // PSDONE timeout on channel 1, then recovery
        apply_reset("t4");
        resp_en[1] = 1'b0;
        clr_mon();
        load("t4a", 2'b10, 0, 4);
        t = 0;
        while (!phase_timeout[1] && t < TOC + 20) begin
            tick(1);
            t++;
        end
        check("t4_to_set", int'(phase_timeout[1]), 1);
        check("t4_to_latency", int'(t >= TOC && t <= TOC + 4), 1);
        wait_idle("t4a", 40);
        check("t4_act1_hold", act(1), 0);
        check("t4_pulses1", inc_cnt[1], 1);
        check("t4_done1", int'(phase_done[1]), 0);
        resp_en[1] = 1'b1;
        clr_mon();
        load("t4b", 2'b10, 0, 4);
        wait_idle("t4b", 400);
        check("t4_act1", act(1), 4);
        check("t4_inc1", inc_cnt[1], 4);
        check("t4_to_final", int'(phase_timeout), 0);
        check("t4_done", int'(phase_done), 3);

        // Lock loss mid-run and re-step after relock
        apply_reset("t5");
        clr_mon();
        load("t5", 2'b01, 8, 0);
        t = 0;
        while (act(0) != 3 && t < 300) begin
            tick(1);
            t++;
        end
        check("t5_reach3", act(0), 3);
        ps_locked[0] = 1'b0;
        tick(2);
        check("t5_act0_zero", act(0), 0);
        check("t5_done0_low", int'(phase_done[0]), 0);
        tick(18);
        check("t5_en_unlocked", en_unlocked, 0);
        clr_mon();
        ps_locked[0] = 1'b1;
        wait_idle("t5", 400);
        check("t5_act0", act(0), 8);
        check("t5_inc0", inc_cnt[0], 8);
        check("t5_dec0", dec_cnt[0], 0);
        check("t5_done", int'(phase_done), 3);

        // Reset while a step is in flight
        apply_reset("t6a");
        clr_mon();
        load("t6", 2'b01, 5, 0);
        t = 0;
        while (!ps_en[0] && t < 20) begin
            tick(1);
            t++;
        end
        check("t6_saw_en", int'(ps_en[0]), 1);
        tick(1);
        apply_reset("t6b");
        clr_mon();
        tick(40);
        check("t6_no_en", inc_cnt[0] + dec_cnt[0] + inc_cnt[1] + dec_cnt[1], 0);
        check("t6_act0", act(0), 0);
        check("t6_done", int'(phase_done), 3);

        // Randomized loads against the round-robin reference
        apply_reset("rnd");
        cur[0] = 0;
        cur[1] = 0;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NCH; i++) begin
                lat[i] = int'($urandom_range(1, 12));
                v[i]   = int'($urandom_range(0, 120)) - 60;
            end
            if (it == 5) v[1] = -int'($urandom_range(256, 300));
            mask = NCH'($urandom_range(1, 3));
            for (int i = 0; i < NCH; i++) begin
                nt[i] = mask[i] ? clampv(v[i]) : cur[i];
                d[i]  = absv(nt[i] - cur[i]);
            end
            clr_mon();
            load("rnd", mask, v[0], v[1]);
            model_grants(d[0], d[1]);
            wait_idle("rnd", (d[0] + d[1]) * 20 + 50);
            check_order("rnd");
            for (int i = 0; i < NCH; i++) begin
                check("rnd_act", act(i), nt[i]);
                check("rnd_inc", inc_cnt[i], (nt[i] > cur[i]) ? d[i] : 0);
                check("rnd_dec", dec_cnt[i], (nt[i] < cur[i]) ? d[i] : 0);
                cur[i] = nt[i];
            end
            check("rnd_onehot", viol, 0);
            check("rnd_done", int'(phase_done), 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
